div_seq: RTL

Sequential iterative divider controller for the MIPS pipeline's HI/LO path. It accepts DIV/DIVU requests from the execute stage through a start/cancel/ready handshake. It runs a 32-iteration restoring division with sign pre/post-processing and presents `{remainder, quotient}` for the execute stage to write into HI/LO. The execute stage holds the pipeline paused while `ready` is low for an active divide.

---
 rtl/div_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential 32-bit restoring divider for the HI/LO path
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      level request, held until ready is observed
//   cancel     abort the current divide; has priority over start
//   is_signed  1 = DIV, 0 = DIVU; sampled with start in IDLE
//   dividend   operand 1; sampled in IDLE
//   divisor    operand 2; sampled in IDLE
//   ready      result valid (DONE state)
//   busy       divide in progress (RUN or FIX state)
//   div_res    {remainder, quotient} -> {HI, LO}

module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cancel,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        ready,
  output logic        busy,
  output logic [63:0] div_res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q,   state_d;
  logic [5:0]  cnt_q,     cnt_d;
  logic [32:0] rem_q,     rem_d;
  logic [31:0] quo_q,     quo_d;
  logic [31:0] dvs_q,     dvs_d;
  logic [31:0] dvd_q,     dvd_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q,      dz_d;
  logic [63:0] res_q,     res_d;

  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [33:0] shifted;
  logic [33:0] trial;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    res_d     = res_q;

    // Two's-complement negation of 0x80000000 yields 0x80000000, which is
    // exactly the unsigned magnitude we want, so no special case is needed.
    dvd_mag = (is_signed && dividend[31]) ? -dividend : dividend;
    dvs_mag = (is_signed && divisor[31])  ? -divisor  : divisor;

    // The partial remainder never reaches bit 32 (it stays below dvs), so
    // widening the shift by one bit is harmless and keeps every bit in use.
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {2'b00, dvs_q};

    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q[31:0] : rem_q[31:0];

    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          quo_d     = dvd_mag;
          dvs_d     = dvs_mag;
          dvd_d     = dividend;
          neg_quo_d = is_signed & (dividend[31] ^ divisor[31]);
          neg_rem_d = is_signed & dividend[31];
          rem_d     = 33'd0;
          cnt_d     = 6'd0;
          if (divisor == 32'd0) begin
            dz_d    = 1'b1;
            state_d = S_FIX;
          end else begin
            dz_d    = 1'b0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          if (!trial[33]) begin
            rem_d = trial[32:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = shifted[32:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          // Divide-by-zero reports all-ones quotient and the untouched dividend.
          res_d   = dz_q ? {dvd_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (cancel || !start) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      rem_q     <= 33'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      dvd_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      res_q     <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      dvd_q     <= dvd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      res_q     <= res_d;
    end
  end

  assign ready   = (state_q == S_DONE);
  assign busy    = (state_q == S_RUN) || (state_q == S_FIX);
  assign div_res = res_q;

endmodule
